noise_hist_ocm_writer: RTL and testbench
========================================

Name: noise_hist_ocm_writer

Overview:
Collects signed 8-bit noise samples from the noise generator output into a 128-bin occurrence histogram. On request, it writes the histogram into the on-chip memory through the 64-bit second port, so the probability distribution of the generated noise can be read back by the NIOS side. This block is the memory-writing end of the on-chip memory path; the noise wrapper is the memory-reading end.

Parameters:
NUM_BINS, 128, histogram bins covering sample values -NUM_BINS/2 .. NUM_BINS/2-1; must be a multiple of 4
CNT_W, 16, bin counter width; 4 counters are packed per 64-bit word
ADDR_W, 14, width of the 64-bit-port word address
ADDR_BASE, 0, OCM word address of histogram word 0
ADDR_STEP, 1, address increment between consecutive histogram words
CLEAR_ON_DUMP, 1, 1 = zero all bins and counters in the cycle after the last dump write

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
sample_in  in  8  signed noise sample (noise_out)
sample_valid  in  1  sample_in is valid this cycle
start_dump  in  1  request to write the histogram to OCM; level or pulse
clear  in  1  zero all bins and counters (honoured only when idle)
address2  out  ADDR_W  OCM port-2 word address
write2  out  1  OCM port-2 write strobe
writedata2  out  64  OCM port-2 write data
byteenable2  out  8  constant 8'hFF
dump_busy  out  1  high while dump writes are in progress
dump_done  out  1  one-cycle pulse after the final write
sample_count  out  32  number of samples binned since the last clear
oor_count  out  16  number of out-of-range samples (saturating)
sat  out  1  sticky flag: some bin reached all-ones
dropped  out  1  sticky flag: sample_valid was asserted while dumping

Behaviour:
- Reset: all bins 0; sample_count 0; oor_count 0; sat, dropped, write2, dump_busy and dump_done 0; address2 = ADDR_BASE; writedata2 = 0; state IDLE.
- States:
  - IDLE (collecting): -> DUMP when start_dump=1.
  - DUMP: -> FINISH after word NUM_BINS/4-1 is written.
  - FINISH: lasts 1 cycle; -> IDLE.
- Binning (IDLE only):
  - sample_valid at edge t with -NUM_BINS/2 <= sample_in <= NUM_BINS/2-1: bin[sample_in + NUM_BINS/2] increments at edge t. The visible count updates the following cycle.
  - sample_count increments at the same edge.
  - Bins saturate at 2^CNT_W-1. Reaching that value sets sat. Further hits hold the bin at the maximum and still increment sample_count.
  - Out-of-range samples are not binned: oor_count increments (saturating) and sample_count does not change.
- Simultaneous sample_valid and start_dump in IDLE: the sample is binned, and the dump includes it.
- Dump timing, with start_dump sampled at edge t:
  - Word k (k = 0 .. NUM_BINS/4-1) is presented in cycle t+1+k.
  - write2 = 1; address2 = ADDR_BASE + k*ADDR_STEP (wraps modulo 2^ADDR_W).
  - writedata2 = {bin[4k+3], bin[4k+2], bin[4k+1], bin[4k]}, with bin[4k] in bits [15:0].
  - dump_busy equals write2. All outputs are registered.
  - With default parameters there are 32 consecutive writes, in cycles t+1 .. t+32.
- FINISH (cycle t+33):
  - write2 = 0 and dump_done = 1 for one cycle.
  - If CLEAR_ON_DUMP=1, bins, sample_count and oor_count are zeroed at that edge. sat and dropped clear only on clear or reset.
- During DUMP or FINISH:
  - sample_valid is ignored (not binned) and sets dropped.
  - start_dump and clear are ignored.
  - A start_dump held high through FINISH starts a new dump from IDLE on the next edge.
- clear in IDLE: everything except address2 returns to reset values at the next edge. clear has priority over a simultaneous sample_valid; start_dump in the same cycle is honoured after the clear, giving an all-zero dump.
- Reset mid-dump: writes stop immediately (write2 = 0 the next cycle) and all state returns to reset values. No dump_done is issued.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs at their reset values; byteenable2 = 8'hFF.
2. Samples 0, 0, -64, 63, 1, then start_dump -> 32 writes at addresses 0..31:
   - word 16 = 64'h0000_0000_0001_0002
   - word 0 = 64'h1
   - word 31 = 64'h0001_0000_0000_0000
   - all other words 0
   - sample_count = 5 before the dump and 0 after dump_done.
3. Samples -100 and 64 -> oor_count = 2, sample_count = 0, all dumped words 0.
4. 65540 consecutive samples of value 5 -> bin 69 dumps as 16'hFFFF (word 17, bits [31:16]); sat = 1; sample_count = 65540.
5. sample_valid held high throughout a dump -> no bin changes during the dump; dropped = 1; dump_done occurs exactly 33 cycles after the start_dump edge.
6. Assert reset at dump word 10 -> write2 falls the next cycle, no dump_done is issued, and a new dump after reset writes 32 zero words.

Source files
------------

// File: rtl/noise_hist_ocm_writer.sv
// ---------------------------------------------------------------------------
// noise_hist_ocm_writer: bins signed noise samples into a histogram and dumps it to OCM port 2.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noise_hist_ocm_writer #(
  parameter int NUM_BINS      = 128,
  parameter int CNT_W         = 16,
  parameter int ADDR_W        = 14,
  parameter int ADDR_BASE     = 0,
  parameter int ADDR_STEP     = 1,
  parameter int CLEAR_ON_DUMP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        sample_in,
  input  logic              sample_valid,
  input  logic              start_dump,
  input  logic              clear,
  output logic [ADDR_W-1:0] address2,
  output logic              write2,
  output logic [63:0]       writedata2,
  output logic [7:0]        byteenable2,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [31:0]       sample_count,
  output logic [15:0]       oor_count,
  output logic              sat,
  output logic              dropped
);

  localparam int c_num_words = NUM_BINS / 4;
  localparam int c_half      = NUM_BINS / 2;
  localparam int c_bin_w     = $clog2(NUM_BINS);
  localparam int c_wsel_w    = $clog2(c_num_words);
  localparam int c_wcnt_w    = $clog2(c_num_words + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DUMP   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      bin_q [NUM_BINS];
  logic [c_wcnt_w-1:0]   word_q;
  logic [31:0]           sample_count_q;
  logic [15:0]           oor_count_q;
  logic                  sat_q;
  logic                  dropped_q;
  logic                  write2_q;
  logic                  dump_done_q;
  logic [ADDR_W-1:0]     address2_q;
  logic [63:0]           writedata2_q;

  logic signed [31:0]    sval;
  logic                  in_range;
  logic [c_bin_w-1:0]    bin_idx;
  logic                  idle;
  logic                  take;
  logic                  hit;
  logic                  oor_hit;
  logic [CNT_W-1:0]      cur_bin;
  logic [CNT_W-1:0]      inc_val;
  logic [c_wsel_w-1:0]   wsel;
  logic [63:0]           wdata_d;

  assign sval     = 32'(signed'(sample_in));
  assign in_range = (sval >= -c_half) && (sval <= c_half - 1);
  assign bin_idx  = c_bin_w'(sample_in + 8'(c_half));
  assign idle     = (state_q == S_IDLE);
  assign take     = idle && sample_valid && !clear;
  assign hit      = take && in_range;
  assign oor_hit  = take && !in_range;
  assign cur_bin  = bin_q[bin_idx];
  assign inc_val  = (cur_bin == c_cnt_max) ? cur_bin : cur_bin + 1'b1;
  assign wsel     = idle ? '0 : word_q[c_wsel_w-1:0];

  // The word registered on the start edge must already see a sample binned on that same edge.
  always_comb begin
    wdata_d = '0;
    for (int j = 0; j < 4; j++) begin
      logic [c_bin_w-1:0] idx;
      idx = {wsel, 2'(j)};
      if (hit && (idx == bin_idx)) begin
        wdata_d[j*CNT_W +: CNT_W] = inc_val;
      end else begin
        wdata_d[j*CNT_W +: CNT_W] = bin_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
      word_q         <= '0;
      sample_count_q <= '0;
      oor_count_q    <= '0;
      sat_q          <= 1'b0;
      dropped_q      <= 1'b0;
      write2_q       <= 1'b0;
      dump_done_q    <= 1'b0;
      address2_q     <= ADDR_W'(ADDR_BASE);
      writedata2_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dump_done_q <= 1'b0;
          if (clear) begin
            for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
            sample_count_q <= '0;
            oor_count_q    <= '0;
            sat_q          <= 1'b0;
            dropped_q      <= 1'b0;
            writedata2_q   <= '0;
          end else begin
            if (hit) begin
              bin_q[bin_idx] <= inc_val;
              sample_count_q <= sample_count_q + 32'd1;
              if (inc_val == c_cnt_max) sat_q <= 1'b1;
            end
            if (oor_hit && (oor_count_q != 16'hFFFF)) begin
              oor_count_q <= oor_count_q + 16'd1;
            end
          end
          if (start_dump) begin
            state_q      <= S_DUMP;
            write2_q     <= 1'b1;
            address2_q   <= ADDR_W'(ADDR_BASE);
            writedata2_q <= clear ? 64'd0 : wdata_d;
            word_q       <= c_wcnt_w'(1);
          end
        end
        S_DUMP: begin
          if (sample_valid) dropped_q <= 1'b1;
          if (word_q == c_wcnt_w'(c_num_words)) begin
            state_q     <= S_FINISH;
            write2_q    <= 1'b0;
            dump_done_q <= 1'b1;
            if (CLEAR_ON_DUMP != 0) begin
              for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
              sample_count_q <= '0;
              oor_count_q    <= '0;
            end
          end else begin
            write2_q     <= 1'b1;
            address2_q   <= address2_q + ADDR_W'(ADDR_STEP);
            writedata2_q <= wdata_d;
            word_q       <= word_q + 1'b1;
          end
        end
        S_FINISH: begin
          if (sample_valid) dropped_q <= 1'b1;
          dump_done_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address2     = address2_q;
  assign write2       = write2_q;
  assign writedata2   = writedata2_q;
  assign byteenable2  = 8'hFF;
  assign dump_busy    = write2_q;
  assign dump_done    = dump_done_q;
  assign sample_count = sample_count_q;
  assign oor_count    = oor_count_q;
  assign sat          = sat_q;
  assign dropped      = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_noise_hist_ocm_writer.sv
// ---------------------------------------------------------------------------
// tb_noise_hist_ocm_writer: directed self-checking bench for noise_hist_ocm_writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_noise_hist_ocm_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        start_dump;
  logic        clear;
  logic [13:0] address2;
  logic        write2;
  logic [63:0] writedata2;
  logic [7:0]  byteenable2;
  logic        dump_busy;
  logic        dump_done;
  logic [31:0] sample_count;
  logic [15:0] oor_count;
  logic        sat;
  logic        dropped;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_w [32];

  always #5 clk = ~clk;

  noise_hist_ocm_writer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .start_dump   (start_dump),
    .clear        (clear),
    .address2     (address2),
    .write2       (write2),
    .writedata2   (writedata2),
    .byteenable2  (byteenable2),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done),
    .sample_count (sample_count),
    .oor_count    (oor_count),
    .sat          (sat),
    .dropped      (dropped)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_w[i] = 64'd0;
  endtask

  task automatic send(input logic [7:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Returns in the FINISH cycle, 33 cycles after the start_dump edge.
  task automatic run_dump();
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k != 0) step();
      chk($sformatf("write2[%0d]", k), {63'd0, write2}, 64'd1);
      chk($sformatf("busy[%0d]", k), {63'd0, dump_busy}, 64'd1);
      chk($sformatf("addr[%0d]", k), {50'd0, address2}, 64'(k));
      chk($sformatf("data[%0d]", k), writedata2, exp_w[k]);
    end
    step();
    chk("finish_write2", {63'd0, write2}, 64'd0);
    chk("finish_done", {63'd0, dump_done}, 64'd1);
  endtask

  initial begin
    int done_seen;
    reset        = 1'b1;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    start_dump   = 1'b0;
    clear        = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();

    // 1: reset state
    chk("rst_write2", {63'd0, write2}, 64'd0);
    chk("rst_busy", {63'd0, dump_busy}, 64'd0);
    chk("rst_done", {63'd0, dump_done}, 64'd0);
    chk("rst_addr", {50'd0, address2}, 64'd0);
    chk("rst_wdata", writedata2, 64'd0);
    chk("rst_be", {56'd0, byteenable2}, 64'hFF);
    chk("rst_count", {32'd0, sample_count}, 64'd0);
    chk("rst_oor", {48'd0, oor_count}, 64'd0);
    chk("rst_sat", {63'd0, sat}, 64'd0);
    chk("rst_dropped", {63'd0, dropped}, 64'd0);

    // 2: small histogram across both range edges
    send(8'h00); send(8'h00); send(8'hC0); send(8'h3F); send(8'h01);
    chk("t2_count", {32'd0, sample_count}, 64'd5);
    clear_exp();
    exp_w[0]  = 64'h0000_0000_0000_0001;
    exp_w[16] = 64'h0000_0000_0001_0002;
    exp_w[31] = 64'h0001_0000_0000_0000;
    run_dump();
    step();
    chk("t2_done_pulse", {63'd0, dump_done}, 64'd0);
    chk("t2_count_after", {32'd0, sample_count}, 64'd0);

    // 3: out-of-range samples
    send(8'h9C); send(8'h40);
    chk("t3_oor", {48'd0, oor_count}, 64'd2);
    chk("t3_count", {32'd0, sample_count}, 64'd0);
    clear_exp();
    run_dump();
    step();
    chk("t3_oor_after", {48'd0, oor_count}, 64'd0);

    // 4: bin saturation
    chk("t4_sat_before", {63'd0, sat}, 64'd0);
    sample_in    = 8'd5;
    sample_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("t4_count", {32'd0, sample_count}, 64'd65540);
    chk("t4_sat", {63'd0, sat}, 64'd1);
    clear_exp();
    exp_w[17] = 64'h0000_0000_FFFF_0000;
    run_dump();
    step();
    chk("t4_sat_sticky", {63'd0, sat}, 64'd1);

    // 5: sample arriving with start_dump is included; samples during dump are dropped
    send(8'hFF); send(8'hFF); send(8'hFF);
    chk("t5_dropped_before", {63'd0, dropped}, 64'd0);
    clear_exp();
    exp_w[15] = 64'h0003_0000_0000_0000;
    exp_w[16] = 64'h0000_0001_0000_0000;
    sample_in    = 8'd2;
    sample_valid = 1'b1;
    run_dump();
    sample_valid = 1'b0;
    step();
    chk("t5_dropped", {63'd0, dropped}, 64'd1);
    chk("t5_count_after", {32'd0, sample_count}, 64'd0);

    // clear returns flags to reset values
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_dropped", {63'd0, dropped}, 64'd0);
    chk("clr_sat", {63'd0, sat}, 64'd0);

    // 6: reset in the middle of a dump
    send(8'h00);
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    repeat (10) step();
    chk("t6_addr10", {50'd0, address2}, 64'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_write2_off", {63'd0, write2}, 64'd0);
    chk("t6_busy_off", {63'd0, dump_busy}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (dump_done) done_seen++;
      step();
    end
    chk("t6_no_done", 64'(done_seen), 64'd0);
    chk("t6_count", {32'd0, sample_count}, 64'd0);
    clear_exp();
    run_dump();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
